// File: rtl/dvi_i2c_if.sv
// Bus bundle between the DVI register-port I2C target and whatever drives its pads.
// reg_we is a valid-only strobe: reg_addr/reg_wdata are meaningful in the cycle it is high, and there is no ready.
interface dvi_i2c_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       reg_we;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       busy;

    modport slave (
        input  scl_in, sda_in,
        output sda_oe, reg_we, reg_addr, reg_wdata, busy
    );

    modport master (
        output scl_in, sda_in,
        input  sda_oe, reg_we, reg_addr, reg_wdata, busy
    );
endinterface

// File: rtl/dvi_i2c_target.sv
// I2C target standing in for the DVI transmitter register port: 256x8 registers,
// auto-incrementing pointer, and a write strobe per data byte received.
module dvi_i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h76,
    parameter int          FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    dvi_i2c_if.slave   bus,
    output logic [3:0] dbg_state
);
    localparam int CW = $clog2(FILT_LEN + 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_DEV_ADDR, ST_DEV_ACK, ST_REG_ADDR, ST_REG_ACK,
        ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
    } state_t;

    logic [1:0]    scl_sync, sda_sync;
    logic          scl_f, sda_f, scl_d, sda_d;
    logic [CW-1:0] scl_cnt, sda_cnt;
    logic          scl_rise, scl_fall, start_ev, stop_ev;

    state_t     state, state_n;
    logic [3:0] bit_cnt, cnt_n;
    logic [7:0] shreg, sh_n, ptr, ptr_n, rd_byte, rd_n, waddr_n, wdata_n;
    logic       oe_n, busy_n, rw, rw_n, we_n, mem_we;
    logic [7:0] shifted, rd_word;
    logic [7:0] mem [256];

    // Idle-high reset values keep the filter from seeing a phantom edge after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_in};
            sda_sync <= {sda_sync[0], bus.sda_in};
            scl_d    <= scl_f;
            sda_d    <= sda_f;
            if (scl_sync[1] != scl_f) begin
                if (scl_cnt == CW'(FILT_LEN - 1)) begin
                    scl_f   <= scl_sync[1];
                    scl_cnt <= '0;
                end else begin
                    scl_cnt <= scl_cnt + CW'(1);
                end
            end else begin
                scl_cnt <= '0;
            end
            if (sda_sync[1] != sda_f) begin
                if (sda_cnt == CW'(FILT_LEN - 1)) begin
                    sda_f   <= sda_sync[1];
                    sda_cnt <= '0;
                end else begin
                    sda_cnt <= sda_cnt + CW'(1);
                end
            end else begin
                sda_cnt <= '0;
            end
        end
    end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_ev  = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_ev   = scl_f & scl_d & ~sda_d & sda_f;
    assign shifted   = {shreg[6:0], sda_f};
    assign rd_word   = mem[ptr];
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        sh_n    = shreg;
        ptr_n   = ptr;
        rd_n    = rd_byte;
        rw_n    = rw;
        oe_n    = bus.sda_oe;
        busy_n  = bus.busy;
        we_n    = 1'b0;
        waddr_n = bus.reg_addr;
        wdata_n = bus.reg_wdata;
        mem_we  = 1'b0;
        if (start_ev) begin
            state_n = ST_DEV_ADDR;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
        end else if (stop_ev) begin
            state_n = ST_IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        sh_n  = shifted;
                        cnt_n = bit_cnt + 4'd1;
                        if (state == ST_WR_DATA && bit_cnt == 4'd7) begin
                            we_n    = 1'b1;
                            waddr_n = ptr;
                            wdata_n = shifted;
                            mem_we  = 1'b1;
                            ptr_n   = ptr + 8'd1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (state == ST_DEV_ADDR) begin
                            if (shreg[7:1] == DEV_ADDR) begin
                                state_n = ST_DEV_ACK;
                                oe_n    = 1'b1;
                                busy_n  = 1'b1;
                                rw_n    = shreg[0];
                            end else begin
                                state_n = ST_IGNORE;
                                busy_n  = 1'b0;
                            end
                        end else if (state == ST_REG_ADDR) begin
                            ptr_n   = shreg;
                            oe_n    = 1'b1;
                            state_n = ST_REG_ACK;
                        end else begin
                            oe_n    = 1'b1;
                            state_n = ST_WR_ACK;
                        end
                    end
                end
                ST_DEV_ACK: begin
                    if (scl_fall) begin
                        cnt_n = 4'd0;
                        if (rw) begin
                            rd_n    = rd_word;
                            oe_n    = ~rd_word[7];
                            state_n = ST_RD_DATA;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = ST_REG_ADDR;
                        end
                    end
                end
                ST_REG_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        oe_n    = 1'b0;
                        cnt_n   = 4'd0;
                        state_n = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            oe_n    = 1'b0;
                            ptr_n   = ptr + 8'd1;
                            state_n = ST_RD_ACK;
                        end else begin
                            oe_n = ~rd_byte[~bit_cnt[2:0]];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise && sda_f) begin
                        state_n = ST_IGNORE;
                        busy_n  = 1'b0;
                        oe_n    = 1'b0;
                    end else if (scl_fall) begin
                        rd_n    = rd_word;
                        oe_n    = ~rd_word[7];
                        cnt_n   = 4'd0;
                        state_n = ST_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            bit_cnt       <= 4'd0;
            shreg         <= 8'd0;
            ptr           <= 8'd0;
            rd_byte       <= 8'd0;
            rw            <= 1'b0;
            bus.sda_oe    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.reg_we    <= 1'b0;
            bus.reg_addr  <= 8'd0;
            bus.reg_wdata <= 8'd0;
        end else begin
            state         <= state_n;
            bit_cnt       <= cnt_n;
            shreg         <= sh_n;
            ptr           <= ptr_n;
            rd_byte       <= rd_n;
            rw            <= rw_n;
            bus.sda_oe    <= oe_n;
            bus.busy      <= busy_n;
            bus.reg_we    <= we_n;
            bus.reg_addr  <= waddr_n;
            bus.reg_wdata <= wdata_n;
        end
    end

    // Register contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr] <= shifted;
    end
endmodule

// File: tb/tb_dvi_i2c_target.sv
// Bench for dvi_i2c_target: bit-banged I2C master, register-file reference model,
// write-strobe scoreboard and read-data checks.
module tb_dvi_i2c_target;
    localparam int Q = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1, m_sda = 1'b1, scl_g = 1'b0, sda_g = 1'b0;
    logic       line_sda;
    logic [3:0] dbg_state;

    always #4 clk = ~clk;

    dvi_i2c_if bus();
    assign line_sda   = m_sda & ~bus.sda_oe;
    assign bus.scl_in = m_scl ^ scl_g;
    assign bus.sda_in = line_sda ^ sda_g;

    dvi_i2c_target dut (
        .clk       (clk),
        .reset     (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    int          checks = 0, errors = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  model_mem [256];
    logic [7:0]  model_ptr = 8'd0;
    logic [7:0]  wbuf [8];
    logic [15:0] mon_e;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Write-strobe monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && bus.reg_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL reg_we_unexpected actual=%h%h required=none", bus.reg_addr, bus.reg_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.reg_addr, bus.reg_wdata} !== mon_e) begin
                    errors++;
                    $display("FAIL reg_we actual=%h%h required=%h", bus.reg_addr, bus.reg_wdata, mon_e);
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic i2c_start;
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; tick(Q);
            m_scl = 1'b1; tick(2 * Q);
            m_scl = 1'b0; tick(Q);
        end
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        ack = line_sda; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic recv_byte(input logic nack, input int abort_bit,
                             output logic [7:0] b, output logic aborted);
        aborted = 1'b0;
        b = 8'd0;
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(Q);
            m_scl = 1'b1; tick(Q);
            b[i] = line_sda;
            if (7 - i == abort_bit) begin
                rst = 1'b1; tick(1);
                check("reset_release_oe", 16'(bus.sda_oe), 16'd0);
                check("reset_busy", 16'(bus.busy), 16'd0);
                rst = 1'b0;
                tick(Q);
                m_scl = 1'b0; tick(Q);
                aborted = 1'b1;
                return;
            end
            tick(Q);
            m_scl = 1'b0; tick(Q);
        end
        m_sda = nack; tick(Q);
        m_scl = 1'b1; tick(2 * Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic do_write(input logic [7:0] ra, input int n, input logic with_stop);
        logic ack;
        i2c_start;
        send_byte(8'hEC, ack);
        check("dev_ack", 16'(ack), 16'd0);
        check("busy_set", 16'(bus.busy), 16'd1);
        send_byte(ra, ack);
        check("reg_ack", 16'(ack), 16'd0);
        model_ptr = ra;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({model_ptr, wbuf[i]});
            model_mem[model_ptr] = wbuf[i];
            model_ptr = model_ptr + 8'd1;
            send_byte(wbuf[i], ack);
            check("data_ack", 16'(ack), 16'd0);
        end
        if (with_stop) begin
            check("busy_before_stop", 16'(bus.busy), 16'd1);
            i2c_stop;
            tick(10);
            check("busy_after_stop", 16'(bus.busy), 16'd0);
        end
    endtask

    task automatic do_read(input logic [7:0] ra, input int n, input int abort_bit);
        logic       ack, aborted;
        logic [7:0] b, e;
        do_write(ra, 0, 1'b0);
        i2c_start;
        send_byte(8'hED, ack);
        check("rd_dev_ack", 16'(ack), 16'd0);
        for (int i = 0; i < n; i++) begin
            rd_q.push_back(model_mem[model_ptr]);
            model_ptr = model_ptr + 8'd1;
            recv_byte(i == n - 1, (i == 0) ? abort_bit : -1, b, aborted);
            if (aborted) begin
                rd_q.delete();
                model_ptr = 8'd0;
                i2c_stop;
                tick(10);
                return;
            end
            e = rd_q.pop_front();
            check("rd_data", 16'(b), 16'(e));
        end
        tick(2);
        check("oe_after_nack", 16'(bus.sda_oe), 16'd0);
        check("busy_after_nack", 16'(bus.busy), 16'd0);
        i2c_stop;
        tick(10);
    endtask

    initial begin
        logic       ack;
        logic [7:0] ra;
        int         n;

        tick(5);
        rst = 1'b0;
        tick(2);
        check("rst_sda_oe", 16'(bus.sda_oe), 16'd0);
        check("rst_reg_we", 16'(bus.reg_we), 16'd0);
        check("rst_reg_addr", 16'(bus.reg_addr), 16'd0);
        check("rst_reg_wdata", 16'(bus.reg_wdata), 16'd0);
        check("rst_busy", 16'(bus.busy), 16'd0);

        // Single register write.
        wbuf[0] = 8'hC0;
        do_write(8'h49, 1, 1'b1);

        // Pointer wrap across 0xFF.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        do_write(8'hFE, 3, 1'b1);

        // Preload then repeated-start read.
        wbuf[0] = 8'h09; wbuf[1] = 8'hA5;
        do_write(8'h21, 2, 1'b1);
        do_read(8'h21, 2, -1);

        // Foreign address is ignored, then a normal transaction.
        i2c_start;
        send_byte(8'hEA, ack);
        check("foreign_nack", 16'(ack), 16'd1);
        check("foreign_busy", 16'(bus.busy), 16'd0);
        send_byte(8'h49, ack);
        check("foreign_data_nack", 16'(ack), 16'd1);
        i2c_stop;
        tick(10);
        wbuf[0] = 8'h5A;
        do_write(8'h10, 1, 1'b1);
        do_read(8'h10, 1, -1);

        // Short glitches on both lines during a write.
        ra = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        fork
            do_write(ra, 4, 1'b1);
            begin
                repeat (30) begin
                    tick($urandom_range(15, 60));
                    if ($urandom_range(0, 1) == 1) scl_g = 1'b1;
                    else sda_g = 1'b1;
                    tick(1);
                    scl_g = 1'b0;
                    sda_g = 1'b0;
                end
            end
        join
        do_read(ra, 4, -1);

        // Reset in the 4th bit of a read that drives zeros.
        wbuf[0] = 8'h00; wbuf[1] = 8'h7E;
        do_write(8'h30, 2, 1'b1);
        do_read(8'h30, 2, 3);
        wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
        do_write(8'h44, 2, 1'b1);
        do_read(8'h44, 2, -1);

        // Random write/readback traffic.
        repeat (3) begin
            ra = 8'($urandom_range(0, 255));
            n  = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            do_write(ra, n, 1'b1);
            do_read(ra, n, -1);
        end

        tick(20);
        check("exp_q_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
